// File: rtl/timer_alarm_ctrl_pkg.sv
// rtl/timer_alarm_ctrl_pkg.sv - Timer command codes, register offsets and FSM states
package timer_alarm_ctrl_pkg;

  localparam logic [2:0] CMD_SET_DIV = 3'b001;
  localparam logic [2:0] CMD_START   = 3'b010;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_COUNT   = 3'd1;
  localparam logic [2:0] REG_PENDING = 3'd2;
  localparam logic [2:0] REG_MASK    = 3'd3;
  localparam logic [2:0] REG_CMP0    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SET_DIV = 2'd2,
    ST_START   = 2'd3
  } state_t;

endpackage

// File: rtl/timer_alarm_channel.sv
// rtl/timer_alarm_channel.sv - one-shot equality compare channel
module timer_alarm_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cmp,
  output logic             fire
);

  logic armed;

  // A CPU write in the same cycle as a match re-arms and suppresses the fire.
  assign fire = armed && (cnt_q == cmp) && !wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp   <= '0;
      armed <= 1'b0;
    end else if (wr_en) begin
      cmp   <= wr_data;
      armed <= 1'b1;
    end else if (fire) begin
      armed <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_alarm_ctrl.sv
// rtl/timer_alarm_ctrl.sv - Timer configuration sequencer with compare alarms and IRQ
module timer_alarm_ctrl
  import timer_alarm_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 9,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipSelect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        irq,
  output logic        tmrChipSelect,
  output logic        tmrWrite,
  output logic        tmrWriteCommand,
  output logic [31:0] tmrDataIn,
  input  logic [31:0] tmrDataOut
);

  state_t             state, state_next;
  logic [DIV_W-1:0]   div;
  logic               start_q, ovr, busy;
  logic               wr_any, wr_ctrl, wr_clr, wr_cfg, wr_count, wr_pending, wr_mask;
  logic [NUM_CH-1:0]  pending, pending_next, mask, mask_next, fire, cmp_wr;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cmp [NUM_CH];
  logic               tmr_cs_n, tmr_wr_n, tmr_cmd_n;
  logic [31:0]        tmr_data_n;

  assign busy       = (state != ST_IDLE);
  assign wr_any     = chipSelect && write;
  assign wr_ctrl    = wr_any && (address == REG_CTRL);
  assign wr_clr     = wr_ctrl && dataIn[31];
  assign wr_cfg     = wr_ctrl && !dataIn[31];
  assign wr_count   = wr_any && (address == REG_COUNT);
  assign wr_pending = wr_any && (address == REG_PENDING);
  assign wr_mask    = wr_any && (address == REG_MASK);

  // Timer outputs are registered from the next state so the strobe lands one clock after the CPU write.
  always_comb begin
    state_next = state;
    tmr_cs_n   = 1'b0;
    tmr_wr_n   = 1'b0;
    tmr_cmd_n  = 1'b0;
    tmr_data_n = '0;
    case (state)
      ST_IDLE: begin
        if (wr_cfg) begin
          state_next = ST_SET_DIV;
          tmr_cs_n   = 1'b1;
          tmr_cmd_n  = 1'b1;
          tmr_data_n = 32'({dataIn[DIV_W-1:0], CMD_SET_DIV});
        end else if (wr_count) begin
          state_next = ST_LOAD;
          tmr_cs_n   = 1'b1;
          tmr_wr_n   = 1'b1;
          tmr_data_n = dataIn;
        end
      end
      ST_SET_DIV: begin
        if (start_q) begin
          state_next = ST_START;
          tmr_cs_n   = 1'b1;
          tmr_cmd_n  = 1'b1;
          tmr_data_n = 32'(CMD_START);
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Set beats W1C on the same bit.
  always_comb begin
    pending_next = (pending & ~(wr_pending ? dataIn[NUM_CH-1:0] : '0)) | fire;
    mask_next    = wr_mask ? dataIn[NUM_CH-1:0] : mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      div             <= '0;
      start_q         <= 1'b0;
      ovr             <= 1'b0;
      tmrChipSelect   <= 1'b0;
      tmrWrite        <= 1'b0;
      tmrWriteCommand <= 1'b0;
      tmrDataIn       <= '0;
      cnt_q           <= '0;
      pending         <= '0;
      mask            <= '0;
      irq             <= 1'b0;
    end else begin
      state           <= state_next;
      tmrChipSelect   <= tmr_cs_n;
      tmrWrite        <= tmr_wr_n;
      tmrWriteCommand <= tmr_cmd_n;
      tmrDataIn       <= tmr_data_n;
      cnt_q           <= tmrDataOut[CNT_W-1:0];
      pending         <= pending_next;
      mask            <= mask_next;
      irq             <= |(pending_next & mask_next);
      if (!busy && wr_cfg) begin
        div     <= dataIn[DIV_W-1:0];
        start_q <= dataIn[9];
      end
      if (wr_clr) begin
        ovr <= 1'b0;
      end else if (busy && (wr_cfg || wr_count)) begin
        ovr <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign cmp_wr[g] = wr_any && (address == REG_CMP0 + 3'(g));
    timer_alarm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (cmp_wr[g]),
      .wr_data (dataIn[CNT_W-1:0]),
      .cnt_q   (cnt_q),
      .cmp     (cmp[g]),
      .fire    (fire[g])
    );
  end

  always_comb begin
    dataOut = '0;
    if (chipSelect) begin
      case (address)
        REG_CTRL: begin
          dataOut     = 32'(div);
          dataOut[31] = busy;
          dataOut[30] = ovr;
        end
        REG_COUNT:   dataOut = tmrDataOut;
        REG_PENDING: dataOut = 32'(pending);
        REG_MASK:    dataOut = 32'(mask);
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (address == REG_CMP0 + 3'(i)) dataOut = 32'(cmp[i]);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// tb/tb_timer_alarm_ctrl.sv - scoreboard bench for timer_alarm_ctrl
module tb_timer_alarm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipSelect, write;
  logic [2:0]  address;
  logic [31:0] dataIn, dataOut, tmrDataIn, tmrDataOut;
  logic        irq, tmrChipSelect, tmrWrite, tmrWriteCommand;
  logic        strobe;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        rd_q[$];
  logic [33:0] tmr_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  timer_alarm_ctrl #(.NUM_CH(4), .DIV_W(9), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .chipSelect      (chipSelect),
    .write           (write),
    .address         (address),
    .dataIn          (dataIn),
    .dataOut         (dataOut),
    .irq             (irq),
    .tmrChipSelect   (tmrChipSelect),
    .tmrWrite        (tmrWrite),
    .tmrWriteCommand (tmrWriteCommand),
    .tmrDataIn       (tmrDataIn),
    .tmrDataOut      (tmrDataOut)
  );

  always @(negedge clk) begin
    if (tmrChipSelect === 1'b1) begin
      checks++;
      if (tmr_q.size() == 0) begin
        errors++;
        $display("FAIL tmr_unexpected: got wr=%0b cmd=%0b data=%h, required no access",
                 tmrWrite, tmrWriteCommand, tmrDataIn);
      end else begin
        logic [33:0] e;
        e = tmr_q.pop_front();
        if ({tmrWrite, tmrWriteCommand, tmrDataIn} !== e) begin
          errors++;
          $display("FAIL tmr_access: got wr=%0b cmd=%0b data=%h, required wr=%0b cmd=%0b data=%h",
                   tmrWrite, tmrWriteCommand, tmrDataIn, e[33], e[32], e[31:0]);
        end
      end
    end
    if (strobe && rd_q.size() != 0) begin
      chk_t        c;
      logic [31:0] act;
      c = rd_q.pop_front();
      case (c.kind)
        0:       act = dataOut;
        1:       act = {31'b0, irq};
        default: act = {tmrChipSelect, tmrWrite, tmrWriteCommand, tmrDataIn[28:0]};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    chipSelect = 1'b1; write = 1'b1; address = a; dataIn = d;
    step(1);
    chipSelect = 1'b0; write = 1'b0; dataIn = '0;
  endtask

  task automatic probe(input int kind, input logic [31:0] e, input string name);
    rd_q.push_back('{kind, e, name});
    strobe = 1'b1;
    step(1);
    strobe = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, input logic [31:0] e, input string name);
    chipSelect = 1'b1; write = 1'b0; address = a;
    probe(0, e, name);
    chipSelect = 1'b0;
  endtask

  task automatic expect_tmr(input logic wr, input logic cmd, input logic [31:0] d);
    tmr_q.push_back({wr, cmd, d});
  endtask

  initial begin
    reset = 1'b1; chipSelect = 1'b0; write = 1'b0; address = '0; dataIn = '0;
    tmrDataOut = '0; strobe = 1'b0;
    step(1);
    reset = 1'b0;

    // reset state
    probe(2, 32'h0, "reset_tmr");
    probe(1, 32'h0, "reset_irq");
    for (int a = 0; a < 8; a++) cpu_read(3'(a), 32'h0, "reset_read");

    // divider + start sequence, busy visible in both states
    expect_tmr(1'b0, 1'b1, 32'h0000_0401);
    expect_tmr(1'b0, 1'b1, 32'h0000_0002);
    cpu_write(3'd0, 32'h0000_0280);
    cpu_read(3'd0, 32'h8000_0080, "busy_set_div");
    cpu_read(3'd0, 32'h8000_0080, "busy_start");
    cpu_read(3'd0, 32'h0000_0080, "idle_after_start");

    // write while busy is dropped and sets ovr
    expect_tmr(1'b0, 1'b1, 32'h0000_0401);
    cpu_write(3'd0, 32'h0000_0080);
    cpu_write(3'd1, 32'h0000_0055);
    cpu_read(3'd0, 32'h4000_0080, "ovr_set");
    cpu_write(3'd0, 32'h8000_0000);
    cpu_read(3'd0, 32'h0000_0080, "ovr_clear");

    // counter load
    expect_tmr(1'b1, 1'b0, 32'hFFFF_F000);
    cpu_write(3'd1, 32'hFFFF_F000);
    cpu_read(3'd0, 32'h8000_0080, "busy_load");
    tmrDataOut = 32'h0000_1234;
    cpu_read(3'd1, 32'h0000_1234, "count_live");

    // reset during SET_DIV: START never issued
    expect_tmr(1'b0, 1'b1, 32'h0000_0401);
    cpu_write(3'd0, 32'h0000_0280);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    probe(2, 32'h0, "reset_mid_tmr");
    step(3);
    cpu_read(3'd0, 32'h0, "reset_mid_ctrl");

    // channel 2 alarm
    tmrDataOut = 32'd4;
    cpu_write(3'd6, 32'd5);
    cpu_write(3'd3, 32'h0000_00F4);
    cpu_read(3'd3, 32'h4, "mask_width");
    cpu_read(3'd6, 32'd5, "cmp2_read");
    tmrDataOut = 32'd5;
    probe(1, 32'h0, "irq_lat0");
    probe(1, 32'h0, "irq_lat1");
    probe(1, 32'h1, "irq_lat2");
    cpu_read(3'd2, 32'h4, "pending_ch2");
    address = 3'd2;
    probe(0, 32'h0, "no_cs_read");
    tmrDataOut = 32'd6;
    cpu_write(3'd2, 32'h4);
    probe(1, 32'h0, "irq_after_w1c");
    cpu_read(3'd2, 32'h0, "pending_w1c");
    tmrDataOut = 32'd5;
    step(3);
    cpu_read(3'd2, 32'h0, "no_refire");

    // jump over cmp never fires; wrap to 0 fires cmp=0
    tmrDataOut = 32'd50;
    cpu_write(3'd7, 32'd100);
    tmrDataOut = 32'd200;
    step(2);
    tmrDataOut = 32'hFFFF_FFFF;
    cpu_write(3'd5, 32'd0);
    step(1);
    tmrDataOut = 32'd0;
    step(2);
    cpu_read(3'd2, 32'h2, "wrap_and_jump");

    // fire and W1C on the same bit in the same cycle
    cpu_write(3'd2, 32'hF);
    cpu_write(3'd3, 32'h1);
    tmrDataOut = 32'd10;
    cpu_write(3'd4, 32'd7);
    tmrDataOut = 32'd7;
    step(2);
    probe(1, 32'h1, "irq_ch0");
    cpu_write(3'd4, 32'd9);
    tmrDataOut = 32'd9;
    step(1);
    cpu_write(3'd2, 32'h1);
    cpu_read(3'd2, 32'h1, "set_beats_w1c");
    probe(1, 32'h1, "irq_held");

    // CMP write on the firing cycle wins
    cpu_write(3'd2, 32'h1);
    cpu_write(3'd4, 32'd11);
    tmrDataOut = 32'd11;
    step(1);
    cpu_write(3'd4, 32'd13);
    step(2);
    cpu_read(3'd2, 32'h0, "write_beats_fire");
    tmrDataOut = 32'd13;
    step(2);
    cpu_read(3'd2, 32'h1, "rearmed_fire");

    step(2);
    checks++;
    if (tmr_q.size() != 0) begin
      errors++;
      $display("FAIL tmr_missing: got %0d outstanding, required 0", tmr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
